gps_transmitter: RTL and testbench



---
 rtl/gps_transmitter.sv | 192 +++++++++++++++++++
 tb/tb_gps_transmitter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/gps_transmitter.sv
// GPZDA sentence serialiser: parallel ASCII time/date fields in, valid/ready byte stream out.
// Optional checksum tail "*C1C0" is built when GPS_TX_CHECKSUM_EN is defined.
module gps_transmitter #(
  parameter int              B         = 8,
  parameter logic [6*B-1:0]  PREFIX    = "$GPZDA",
  parameter logic [B-1:0]    SEPARATOR = ",",
  parameter logic [2*B-1:0]  CENTURY   = "20"
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           start,
  input  logic [2*B-1:0] hour,
  input  logic [2*B-1:0] minute,
  input  logic [2*B-1:0] second,
  input  logic [2*B-1:0] day,
  input  logic [2*B-1:0] month,
  input  logic [2*B-1:0] year,
  input  logic           ready,
  output logic           load,
  output logic [B-1:0]   data,
  output logic           busy,
  output logic           done,
  output logic [2:0]     state
);

  // Handshake: a byte moves on a clock edge where load && ready; while load=1
  // and ready=0 the byte on data and load itself stay unchanged.

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_BODY  = 3'd1;
`ifdef GPS_TX_CHECKSUM_EN
  localparam logic [2:0] S_STAR  = 3'd2;
  localparam logic [2:0] S_SUMHI = 3'd3;
  localparam logic [2:0] S_SUMLO = 3'd4;
`endif
  localparam logic [2:0] S_CR    = 3'd5;
  localparam logic [2:0] S_LF    = 3'd6;

  localparam logic [5:0]   LAST_INDEX = 6'd32;
  localparam logic [B-1:0] CH_DOT     = B'(8'h2E);
  localparam logic [B-1:0] CH_ZERO    = B'(8'h30);
  localparam logic [B-1:0] CH_CR      = B'(8'h0D);
  localparam logic [B-1:0] CH_LF      = B'(8'h0A);
`ifdef GPS_TX_CHECKSUM_EN
  localparam logic [B-1:0] CH_STAR    = B'(8'h2A);
`endif

  logic [2:0]     fsm;
  logic [5:0]     index;
  logic [2*B-1:0] hour_s, minute_s, second_s, day_s, month_s, year_s;
  logic [B-1:0]   body_char;
  logic [B-1:0]   data_c;
  logic           xfer;
`ifdef GPS_TX_CHECKSUM_EN
  logic [B-1:0]   checksum;

  function automatic logic [B-1:0] hex_char(input logic [3:0] nib);
    if (nib < 4'd10) return {{(B-4){1'b0}}, nib} + B'(8'h30);
    else             return {{(B-4){1'b0}}, nib} + B'(8'h37);
  endfunction
`endif

  assign load  = (fsm != S_IDLE);
  assign busy  = load;
  assign xfer  = load && ready;
  assign data  = data_c;
  assign state = fsm;

  // Fixed body layout: $GPZDA,hhmmss.00,dd,mm,CCyy,00,00
  always_comb begin
    body_char = '0;
    case (index)
      6'd0:  body_char = PREFIX[6*B-1 -: B];
      6'd1:  body_char = PREFIX[5*B-1 -: B];
      6'd2:  body_char = PREFIX[4*B-1 -: B];
      6'd3:  body_char = PREFIX[3*B-1 -: B];
      6'd4:  body_char = PREFIX[2*B-1 -: B];
      6'd5:  body_char = PREFIX[B-1 -: B];
      6'd6:  body_char = SEPARATOR;
      6'd7:  body_char = hour_s[2*B-1 -: B];
      6'd8:  body_char = hour_s[B-1 -: B];
      6'd9:  body_char = minute_s[2*B-1 -: B];
      6'd10: body_char = minute_s[B-1 -: B];
      6'd11: body_char = second_s[2*B-1 -: B];
      6'd12: body_char = second_s[B-1 -: B];
      6'd13: body_char = CH_DOT;
      6'd14: body_char = CH_ZERO;
      6'd15: body_char = CH_ZERO;
      6'd16: body_char = SEPARATOR;
      6'd17: body_char = day_s[2*B-1 -: B];
      6'd18: body_char = day_s[B-1 -: B];
      6'd19: body_char = SEPARATOR;
      6'd20: body_char = month_s[2*B-1 -: B];
      6'd21: body_char = month_s[B-1 -: B];
      6'd22: body_char = SEPARATOR;
      6'd23: body_char = CENTURY[2*B-1 -: B];
      6'd24: body_char = CENTURY[B-1 -: B];
      6'd25: body_char = year_s[2*B-1 -: B];
      6'd26: body_char = year_s[B-1 -: B];
      6'd27: body_char = SEPARATOR;
      6'd28: body_char = CH_ZERO;
      6'd29: body_char = CH_ZERO;
      6'd30: body_char = SEPARATOR;
      6'd31: body_char = CH_ZERO;
      6'd32: body_char = CH_ZERO;
      default: body_char = '0;
    endcase
  end

  always_comb begin
    data_c = '0;
    case (fsm)
      S_BODY:  data_c = body_char;
`ifdef GPS_TX_CHECKSUM_EN
      S_STAR:  data_c = CH_STAR;
      S_SUMHI: data_c = hex_char(checksum[7:4]);
      S_SUMLO: data_c = hex_char(checksum[3:0]);
`endif
      S_CR:    data_c = CH_CR;
      S_LF:    data_c = CH_LF;
      default: data_c = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fsm      <= S_IDLE;
      index    <= '0;
      done     <= 1'b0;
      hour_s   <= '0;
      minute_s <= '0;
      second_s <= '0;
      day_s    <= '0;
      month_s  <= '0;
      year_s   <= '0;
`ifdef GPS_TX_CHECKSUM_EN
      checksum <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (fsm)
        S_IDLE: begin
          if (start) begin
            hour_s   <= hour;
            minute_s <= minute;
            second_s <= second;
            day_s    <= day;
            month_s  <= month;
            year_s   <= year;
            index    <= '0;
`ifdef GPS_TX_CHECKSUM_EN
            checksum <= '0;
`endif
            fsm      <= S_BODY;
          end
        end
        S_BODY: begin
          if (xfer) begin
`ifdef GPS_TX_CHECKSUM_EN
            // '$' at index 0 is excluded from the XOR
            if (index != 6'd0) checksum <= checksum ^ body_char;
`endif
            if (index == LAST_INDEX) begin
              index <= '0;
`ifdef GPS_TX_CHECKSUM_EN
              fsm   <= S_STAR;
`else
              fsm   <= S_CR;
`endif
            end else begin
              index <= index + 6'd1;
            end
          end
        end
`ifdef GPS_TX_CHECKSUM_EN
        S_STAR:  if (xfer) fsm <= S_SUMHI;
        S_SUMHI: if (xfer) fsm <= S_SUMLO;
        S_SUMLO: if (xfer) fsm <= S_CR;
`endif
        S_CR:    if (xfer) fsm <= S_LF;
        S_LF: begin
          if (xfer) begin
            fsm  <= S_IDLE;
            done <= 1'b1;
          end
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gps_transmitter.sv
// Directed bench for gps_transmitter: vector table of field sets with hand-computed
// checksum characters, plus reset-abort and back-to-back sequences.
module tb_gps_transmitter;

`ifdef GPS_TX_CHECKSUM_EN
  localparam int LEN = 38;
`else
  localparam int LEN = 35;
`endif
  localparam int BUDGET = 400;

  logic        clock, reset_n, start, ready;
  logic [15:0] hour, minute, second, day, month, year;
  logic        load, busy, done;
  logic [7:0]  data;
  logic [2:0]  state;

  gps_transmitter dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .hour(hour), .minute(minute), .second(second),
    .day(day), .month(month), .year(year),
    .ready(ready), .load(load), .data(data),
    .busy(busy), .done(done), .state(state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // mode: 0 ready=1, 1 random backpressure with 10-cycle stalls,
  //       2 fields zeroed after start, 3 start pulses while busy
  typedef struct {
    logic [15:0] hour, minute, second, day, month, year;
    logic [7:0]  c1, c0;
    int          mode;
  } vec_t;

  vec_t       vecs[6];
  logic [7:0] exp_q[$];
  int         tests = 0;
  int         fails = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_fields(input int v);
    hour = vecs[v].hour; minute = vecs[v].minute; second = vecs[v].second;
    day = vecs[v].day; month = vecs[v].month; year = vecs[v].year;
  endtask

  task automatic build_expected(input int v);
    exp_q.delete();
    exp_q.push_back("$"); exp_q.push_back("G"); exp_q.push_back("P");
    exp_q.push_back("Z"); exp_q.push_back("D"); exp_q.push_back("A");
    exp_q.push_back(",");
    exp_q.push_back(vecs[v].hour[15:8]);   exp_q.push_back(vecs[v].hour[7:0]);
    exp_q.push_back(vecs[v].minute[15:8]); exp_q.push_back(vecs[v].minute[7:0]);
    exp_q.push_back(vecs[v].second[15:8]); exp_q.push_back(vecs[v].second[7:0]);
    exp_q.push_back("."); exp_q.push_back("0"); exp_q.push_back("0");
    exp_q.push_back(",");
    exp_q.push_back(vecs[v].day[15:8]);    exp_q.push_back(vecs[v].day[7:0]);
    exp_q.push_back(",");
    exp_q.push_back(vecs[v].month[15:8]);  exp_q.push_back(vecs[v].month[7:0]);
    exp_q.push_back(",");
    exp_q.push_back("2"); exp_q.push_back("0");
    exp_q.push_back(vecs[v].year[15:8]);   exp_q.push_back(vecs[v].year[7:0]);
    exp_q.push_back(",");
    exp_q.push_back("0"); exp_q.push_back("0"); exp_q.push_back(",");
    exp_q.push_back("0"); exp_q.push_back("0");
`ifdef GPS_TX_CHECKSUM_EN
    exp_q.push_back("*"); exp_q.push_back(vecs[v].c1); exp_q.push_back(vecs[v].c0);
`endif
    exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
  endtask

  // chained=1: start was already raised on the previous done cycle.
  // next_v>=0: raise start with those fields on this sentence's done cycle.
  task automatic send(input int v, input bit chained, input int next_v);
    int         mode, accepted, load_cycles, cycles, stall_left, stall_no;
    bit         prev_stall, abort;
    logic [7:0] prev_data;
    mode = vecs[v].mode;
    accepted = 0; load_cycles = 0; cycles = 0; stall_left = 0; stall_no = 0;
    prev_stall = 1'b0; abort = 1'b0; prev_data = '0;
    build_expected(v);
    if (!chained) begin
      apply_fields(v);
      start = 1'b1;
    end
    tick();
    start = 1'b0;
    if (mode == 2) begin
      hour = "00"; minute = "00"; second = "00"; day = "00"; month = "00"; year = "00";
    end
    check("busy_rise", busy, 1);
    while (exp_q.size() > 0 && !abort) begin
      if (mode == 1) begin
        if (stall_left > 0) begin
          ready = 1'b0; stall_left--;
        end else if ((accepted == 5 && stall_no == 0) || (accepted == 20 && stall_no == 1)) begin
          ready = 1'b0; stall_left = 9; stall_no++;
        end else begin
          ready = 1'($urandom_range(0, 1));
        end
      end else begin
        ready = 1'b1;
      end
      if (mode == 3) start = 1'($urandom_range(0, 1));
      check("load_held", load, 1);
      if (!load) abort = 1'b1;
      else begin
        if (prev_stall) check("stall_hold", data, prev_data);
        if (ready) begin
          check($sformatf("byte%0d", accepted), data, exp_q.pop_front());
          accepted++;
        end
        load_cycles++;
      end
      prev_stall = !ready;
      prev_data  = data;
      tick();
      cycles++;
      if (cycles > BUDGET) begin
        check("timeout", cycles, BUDGET);
        abort = 1'b1;
      end
    end
    start = 1'b0;
    ready = 1'b1;
    if (mode != 1) check("load_cycles", load_cycles, LEN);
    check("done_pulse", done, 1);
    check("done_load", load, 0);
    check("done_busy", busy, 0);
    check("done_state", state, 0);
    if (next_v >= 0) begin
      apply_fields(next_v);
      start = 1'b1;
    end else begin
      tick();
      check("done_clear", done, 0);
      for (int k = 0; k < 3; k++) begin
        check("no_extra", load, 0);
        tick();
      end
    end
  endtask

  initial begin
    vecs[0] = '{"12", "34", "56", "09", "10", "21", "6", "8", 0};
    vecs[1] = '{"12", "34", "56", "09", "10", "21", "6", "8", 1};
    vecs[2] = '{"12", "34", "56", "09", "10", "21", "6", "8", 2};
    vecs[3] = '{"23", "59", "59", "31", "12", "99", "6", "4", 3};
    vecs[4] = '{"AB", "00", "00", "01", "01", "00", "6", "7", 0};
    vecs[5] = '{16'hCB00, "00", "00", "01", "01", "00", "A", "F", 1};

    reset_n = 1'b0; start = 1'b0; ready = 1'b0;
    hour = '0; minute = '0; second = '0; day = '0; month = '0; year = '0;
    tick(); tick();
    check("rst_load", load, 0);
    check("rst_data", data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_state", state, 0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++)
      send(i, (i == 4), (i == 3) ? 4 : -1);

    // Abort after 15 accepted bytes, then a clean sentence from '$'
    apply_fields(0);
    start = 1'b1;
    tick();
    start = 1'b0;
    ready = 1'b1;
    repeat (15) tick();
    check("pre_abort_byte", data, "0");
    #1 reset_n = 1'b0;
    #1;
    check("abort_load", load, 0);
    check("abort_busy", busy, 0);
    check("abort_data", data, 0);
    check("abort_state", state, 0);
    #2 reset_n = 1'b1;
    tick();
    check("no_resume", load, 0);
    send(0, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
